prog_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory behind the boot ROM, writing the same image format the ROMs hold. A host streams a 2-byte length followed by the image. The loader writes each image byte to successive memory addresses starting at 0 and checks the 4-byte "ASRM" magic (0x41 0x53 0x52 0x4d). While loading, it holds the CPU in reset and releases it on success.

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_loader.sv | 105 ++++++++++
 tb/tb_prog_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, image magic and length-field width.
// The ROM generator and software tools use the same MAGIC bytes.
package prog_loader_pkg;

    localparam int LEN_W     = 16;
    localparam int MAGIC_LEN = 4;

    // Index 0 is the first magic byte on the wire ("ASRM").
    localparam logic [MAGIC_LEN-1:0][7:0] MAGIC = {8'h4d, 8'h52, 8'h53, 8'h41};

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_MAGIC,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams a length-prefixed image into instruction memory and checks its magic, holding the CPU until done.
// Latency: a byte accepted in cycle N is written (mem_we) in cycle N+1; done/error follow the same timing.
// Backpressure: in_ready depends only on state; high while loading, low in DONE/ERROR.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MAGIC_LEN);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_full;
    logic [LEN_W-1:0]   cnt_inc;
    // One bit wider than the address so a full 2^ADDR_W image is representable.
    logic [ADDR_W:0]    cnt;
    logic               accept;
    logic               wr_nxt;

    assign in_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_MAGIC)  || (state == ST_DATA);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERROR);
    assign cpu_hold = (state != ST_DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        len_full  = {in_data, len[7:0]};
        cnt_inc   = LEN_W'(cnt) + LEN_W'(1);
        case (state)
            ST_LEN_LO: begin
                if (accept) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_full < MIN_LEN || len_full > MAX_LEN) state_nxt = ST_ERROR;
                    else                                          state_nxt = ST_MAGIC;
                end
            end
            ST_MAGIC: begin
                if (accept) begin
                    if (in_data == MAGIC[cnt[1:0]]) begin
                        wr_nxt = 1'b1;
                        if (cnt_inc == MIN_LEN)
                            state_nxt = (len == MIN_LEN) ? ST_DONE : ST_DATA;
                    end else begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_nxt = 1'b1;
                    if (cnt_inc == len) state_nxt = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    // start wins over a byte accepted in the same cycle: its write is dropped.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            state    <= ST_LEN_LO;
            len      <= '0;
            cnt      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= wr_nxt;
            if (state == ST_LEN_LO && accept)
                len[7:0] <= in_data;
            if (state == ST_LEN_HI && accept) begin
                len[LEN_W-1:8] <= in_data;
                cnt            <= '0;
            end
            if (wr_nxt) begin
                mem_addr <= cnt[ADDR_W-1:0];
                mem_data <= in_data;
                cnt      <= cnt + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a list-level model predicts the writes and final status of each load.
module tb_prog_loader;

    localparam int ADDR_W = 9;
    localparam int MAXB   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t      wr_q[$];
    bit [7:0] img_q[$];
    int       exp_addr[$];
    int       exp_data[$];
    bit       exp_done;
    bit       exp_err;
    int       n_send;
    bit [7:0] magic_b[4] = '{8'h41, 8'h53, 8'h52, 8'h4d};

    int cyc = 0;
    int last_we_cyc;
    int first_done_cyc;
    bit prev_acc = 1'b0;

    always @(posedge clk) cyc++;

    // Write monitor: every write must follow a byte handshake on the previous edge.
    always @(negedge clk) begin
        if (mem_we) begin
            chk("wr_latency", prev_acc, 1);
            wr_q.push_back('{addr: int'(mem_addr), data: int'(mem_data), cyc: cyc});
            last_we_cyc = cyc;
        end
        if (done && first_done_cyc < 0) first_done_cyc = cyc;
        prev_acc = in_valid && in_ready && !start && !reset;
    end

    // Reference: the loader writes the image prefix until magic mismatch or len bytes.
    task automatic model(input int len);
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        n_send   = 0;
        if (len < 4 || len > MAXB) begin
            exp_err = 1;
        end else begin
            for (int i = 0; i < len && i < img_q.size(); i++) begin
                n_send++;
                if (i < 4 && img_q[i] != magic_b[i]) begin
                    exp_err = 1;
                    break;
                end
                exp_addr.push_back(i);
                exp_data.push_back(int'(img_q[i]));
            end
            if (!exp_err && exp_addr.size() == len) exp_done = 1;
        end
    endtask

    task automatic build_img(input int n, input int bad_idx);
        bit [7:0] b;
        img_q.delete();
        for (int i = 0; i < n; i++) begin
            b = (i < 4) ? magic_b[i] : 8'($urandom);
            if (i == bad_idx) b = b ^ 8'h01;
            img_q.push_back(b);
        end
    endtask

    // Entered and left at posedge+1; returns just after the edge that accepted the byte.
    task automatic send_byte(input bit [7:0] b, input bit throttle);
        bit got;
        if (throttle && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        last_we_cyc    = -1;
        first_done_cyc = -1;
    endtask

    task automatic run_load(input string tag, input int len, input bit throttle);
        bit [15:0] l16;
        int        n;
        l16 = 16'(len);
        model(len);
        clear_mon();
        send_byte(l16[7:0], throttle);
        send_byte(l16[15:8], throttle);
        for (int i = 0; i < n_send; i++) send_byte(img_q[i], throttle);
        @(negedge clk);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_cpu_hold"}, cpu_hold, !exp_done);
        if (exp_done || exp_err) chk({tag, "_in_ready"}, in_ready, 0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_wr_count"}, wr_q.size(), exp_addr.size());
        n = (wr_q.size() < exp_addr.size()) ? wr_q.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, wr_q[i].addr, exp_addr[i]);
            chk({tag, "_data"}, wr_q[i].data, exp_data[i]);
        end
        if (exp_done) chk({tag, "_done_with_last_we"}, first_done_cyc, last_we_cyc);
        if (!throttle && wr_q.size() > 1)
            chk({tag, "_back_to_back"}, wr_q[$].cyc - wr_q[0].cyc, wr_q.size() - 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_data, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;

        img_q = '{8'h41, 8'h53, 8'h52, 8'h4d, 8'h14, 8'h3c};
        run_load("nominal", 6, 0);

        pulse_start();
        img_q = '{8'h41, 8'h53, 8'h00};
        run_load("bad_magic", 16, 0);

        pulse_start();
        build_img(3, -1);
        run_load("len3", 3, 0);

        pulse_start();
        build_img(8, -1);
        run_load("len201", 'h201, 0);

        pulse_start();
        build_img(MAXB, -1);
        run_load("len200", 'h200, 0);
        if (wr_q.size() > 0) chk("len200_last_addr", wr_q[$].addr, 'h1ff);

        pulse_start();
        build_img('h186, -1);
        run_load("throttle", 'h186, 1);

        pulse_start();
        build_img(4, -1);
        run_load("len4", 4, 0);

        // Restart during DATA with a byte offered in the same cycle.
        pulse_start();
        build_img('h40, -1);
        clear_mon();
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 'h20; i++) send_byte(img_q[i], 0);
        in_valid = 1'b1;
        in_data  = img_q['h20];
        start    = 1'b1;
        @(negedge clk);
        chk("restart_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("restart_mem_we", mem_we, 0);
        chk("restart_in_ready_after", in_ready, 1);
        chk("restart_cpu_hold", cpu_hold, 1);
        chk("restart_done", done, 0);
        chk("restart_error", error, 0);
        chk("restart_wr_count", wr_q.size(), 'h20);
        @(posedge clk);
        #1;
        build_img('h30, -1);
        run_load("after_restart", 'h30, 0);

        // Reset asserted while in MAGIC.
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h41, 0);
        send_byte(8'h53, 0);
        in_valid = 1'b1;
        in_data  = 8'h52;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        build_img(9, -1);
        run_load("after_reset", 9, 1);

        // Random loads: random length, occasional corrupted magic byte.
        for (int t = 0; t < 12; t++) begin
            int len;
            int bad;
            len = $urandom_range(1, 70);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            pulse_start();
            build_img(len, bad);
            run_load("rand", len, t[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
